mc_ctrl_fsm: RTL and testbench
==============================

Name: mc_ctrl_fsm

Overview:
Multi-cycle MIPS main controller, directly upstream of the datapath. Decodes the IR opcode/funct it is fed from the datapath and steps through fetch/decode/execute/memory/writeback states. It drives every datapath control strobe (PCSource, lorD, ALU_Control, ALUSrcA/B, RegDst, RegWrite, IRWrite, MemtoReg, PCWrite, PCWriteCond, Branch, S) and the memory request strobes. It stalls on MIO_ready and squashes writeback on arithmetic overflow.

Parameters:
RESET_STATE, 5'd0, state entered on rst (IF).
ERR_STATE, 5'd31, code for the illegal-instruction trap state.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
OPcode  in  6  inst[31:26] from datapath IR
Fun  in  6  inst[5:0] from datapath IR
MIO_ready  in  1  memory/IO transfer done this cycle
zero  in  1  ALU zero flag
overflow  in  1  ALU signed overflow flag
PCSource  out  2  00 ALU result, 01 ALUOut (branch target), 10 jump target, 11 rs (jr)
lorD  out  1  0 memory address = PC, 1 = ALUOut
ALU_Control  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt, 100 nor
ALUSrcA  out  1  0 PC, 1 reg A
ALUSrcB  out  2  00 reg B, 01 const 4, 10 ext imm, 11 ext imm<<2
RegWrite  out  1  register file write enable
RegDst  out  2  00 rt, 01 rd, 10 $31
IRWrite  out  1  IR load
MemtoReg  out  2  00 ALUOut, 01 MDR, 10 {imm,16'h0}, 11 PC
PCWrite  out  1  unconditional PC load
PCWriteCond  out  1  conditional PC load
Branch  out  1  1 beq (take on zero), 0 bne (take on ~zero)
S  out  1  1 sign-extend imm, 0 zero-extend
MemRead  out  1  memory read request
MemWrite  out  1  memory write request
state_out  out  5  current state code, debug

Behaviour:
- State register: 5 bits, async reset to IF (0). All outputs decoded combinationally from state. Exception: IRWrite/PCWrite in IF and state advance in IF/MEM_RD/MEM_WR are gated by MIO_ready.
- Default value of every strobe in any state: 0. During/after reset (IF): MemRead=1, ALUSrcB=01, ALU_Control=010, S=1, IRWrite=PCWrite=MIO_ready, rest 0.
- States:
  - IF(0): lorD=0, MemRead=1, ALUSrcA=0, ALUSrcB=01, add, PCSource=00. Holds while MIO_ready=0. On MIO_ready=1 → ID.
  - ID(1): ALUSrcA=0, ALUSrcB=11, add, S=1. Decode to next state:
    - R-type (op 000000) with Fun 001000 → JR; other supported funct (100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt, 100111 nor) → R_EXE.
    - lw 100011 / sw 101011 → MEM_ADDR; beq 000100 → BEQ; bne 000101 → BNE; j 000010 → J; jal 000011 → JAL; lui 001111 → LUI_WB.
    - addi 001000 / slti 001010 / andi 001100 / ori 001101 → I_EXE.
    - Anything else → ERR.
  - R_EXE(2): ALUSrcA=1, ALUSrcB=00, ALU_Control per funct. → R_WB.
  - R_WB(3): RegDst=01, MemtoReg=00, RegWrite=~ovf_flag. → IF.
  - I_EXE(4): ALUSrcA=1, ALUSrcB=10, S=0 for andi/ori else 1, ALU_Control per op (add/slt/and/or). → I_WB.
  - I_WB(5): RegDst=00, MemtoReg=00, RegWrite=~ovf_flag. → IF.
  - MEM_ADDR(6): ALUSrcA=1, ALUSrcB=10, S=1, add. lw → MEM_RD; sw → MEM_WR.
  - MEM_RD(7): lorD=1, MemRead=1. Holds until MIO_ready, then → MEM_WB.
  - MEM_WB(8): RegDst=00, MemtoReg=01, RegWrite=1. → IF.
  - MEM_WR(9): lorD=1, MemWrite=1. Holds until MIO_ready, then → IF.
  - BEQ(10)/BNE(11): ALUSrcA=1, ALUSrcB=00, sub, PCSource=01, PCWriteCond=1, Branch=1 (BEQ) / 0 (BNE). → IF.
  - J(12): PCSource=10, PCWrite=1. → IF.
  - JAL(13): PCSource=10, PCWrite=1, RegDst=10, MemtoReg=11, RegWrite=1. → IF.
  - JR(14): PCSource=11, PCWrite=1. → IF.
  - LUI_WB(15): RegDst=00, MemtoReg=10, RegWrite=1. → IF.
  - ERR(31): all strobes 0. Stays until rst.
- ovf_flag: register, async reset 0. Loaded at end of R_EXE with overflow&(funct add|sub) and at end of I_EXE with overflow&addi. Cleared in IF.
- Latency with MIO_ready tied 1: R/I/sw 4 cycles, lw 5, beq/bne/j/jal/jr/lui 3.
- rst mid-instruction: immediate return to IF, ovf_flag cleared, no partial RegWrite/MemWrite after the edge.

Test Plan:
- rst=1 then 0, MIO_ready=0 for 3 cycles → state_out=0, IRWrite=PCWrite=0, MemRead=1; MIO_ready=1 → IRWrite=PCWrite=1, next state 1.
- OPcode=000000, Fun=100000, MIO_ready=1, overflow=0 → states 0,1,2,3,0; RegWrite=1 with RegDst=01 only in state 3; ALU_Control=010 in state 2.
- addi (001000) with overflow=1 during I_EXE → I_WB has RegWrite=0; next addi with overflow=0 → RegWrite=1.
- lw with MIO_ready=0 for 2 cycles in MEM_RD → state 7 held 3 cycles, lorD=1; then state 8, MemtoReg=01, RegWrite=1.
- beq → state 10, PCWriteCond=1, Branch=1, PCSource=01, ALU_Control=110; bne → state 11, Branch=0; jal → state 13, RegDst=10, MemtoReg=11, PCWrite=1.
- OPcode=111111 → state 31 held indefinitely, all strobes 0; assert rst in state 7 → state 0 asynchronously.

Source files
------------

// File: rtl/mc_ctrl_fsm_if.sv
// Controller <-> datapath bundle for the multi-cycle MIPS core.
//   Datapath -> controller: OPcode, Fun (IR fields), MIO_ready, zero, overflow
//   Controller -> datapath: every mux select / write strobe, memory requests,
//                           and the current state code for debug.
// master: the controller side.  slave: the datapath / memory side.
interface mc_ctrl_fsm_if;
    logic [5:0] OPcode;
    logic [5:0] Fun;
    logic       MIO_ready;
    logic       zero;
    logic       overflow;

    logic [1:0] PCSource;
    logic       lorD;
    logic [2:0] ALU_Control;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic       RegWrite;
    logic [1:0] RegDst;
    logic       IRWrite;
    logic [1:0] MemtoReg;
    logic       PCWrite;
    logic       PCWriteCond;
    logic       Branch;
    logic       S;
    logic       MemRead;
    logic       MemWrite;
    logic [4:0] state_out;

    // zero is carried for the datapath's branch qualification (PCWriteCond &
    // (Branch ? zero : ~zero)); the controller itself never needs it.
    modport master (
        input  OPcode, Fun, MIO_ready, zero, overflow,
        output PCSource, lorD, ALU_Control, ALUSrcA, ALUSrcB, RegWrite, RegDst,
               IRWrite, MemtoReg, PCWrite, PCWriteCond, Branch, S, MemRead,
               MemWrite, state_out
    );

    modport slave (
        output OPcode, Fun, MIO_ready, zero, overflow,
        input  PCSource, lorD, ALU_Control, ALUSrcA, ALUSrcB, RegWrite, RegDst,
               IRWrite, MemtoReg, PCWrite, PCWriteCond, Branch, S, MemRead,
               MemWrite, state_out
    );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS main controller.
// Steps IF -> ID -> execute/memory/writeback states, decoding OPcode/Fun held
// in the datapath IR. All strobes are Moore outputs of the state, except the
// IF fetch strobes (IRWrite/PCWrite), which are qualified by MIO_ready.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset, returns to IF
//   bus  - mc_ctrl_fsm_if.master, datapath inputs and all control strobes
module mc_ctrl_fsm #(
    parameter logic [4:0] RESET_STATE = 5'd0,
    parameter logic [4:0] ERR_STATE   = 5'd31
) (
    input  logic          clk,
    input  logic          rst,
    mc_ctrl_fsm_if.master bus
);

    localparam logic [4:0] ST_IF       = 5'd0;
    localparam logic [4:0] ST_ID       = 5'd1;
    localparam logic [4:0] ST_R_EXE    = 5'd2;
    localparam logic [4:0] ST_R_WB     = 5'd3;
    localparam logic [4:0] ST_I_EXE    = 5'd4;
    localparam logic [4:0] ST_I_WB     = 5'd5;
    localparam logic [4:0] ST_MEM_ADDR = 5'd6;
    localparam logic [4:0] ST_MEM_RD   = 5'd7;
    localparam logic [4:0] ST_MEM_WB   = 5'd8;
    localparam logic [4:0] ST_MEM_WR   = 5'd9;
    localparam logic [4:0] ST_BEQ      = 5'd10;
    localparam logic [4:0] ST_BNE      = 5'd11;
    localparam logic [4:0] ST_J        = 5'd12;
    localparam logic [4:0] ST_JAL      = 5'd13;
    localparam logic [4:0] ST_JR       = 5'd14;
    localparam logic [4:0] ST_LUI_WB   = 5'd15;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LUI  = 6'b001111;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    localparam logic [5:0] F_JR  = 6'b001000;
    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;
    localparam logic [5:0] F_NOR = 6'b100111;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;
    localparam logic [2:0] ALU_NOR = 3'b100;

    logic [4:0] state_q, state_d;
    logic       ovf_q, ovf_d;
    logic [4:0] id_target;
    logic [2:0] r_alu;
    logic [2:0] i_alu;

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RESET_STATE;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ovf_q   <= ovf_d;
        end
    end

    // ---------------- decode helpers ----------------
    always_comb begin
        id_target = ERR_STATE;
        case (bus.OPcode)
            OP_R: begin
                case (bus.Fun)
                    F_JR:                                     id_target = ST_JR;
                    F_ADD, F_SUB, F_AND, F_OR, F_SLT, F_NOR:  id_target = ST_R_EXE;
                    default:                                  id_target = ERR_STATE;
                endcase
            end
            OP_LW, OP_SW:                      id_target = ST_MEM_ADDR;
            OP_BEQ:                            id_target = ST_BEQ;
            OP_BNE:                            id_target = ST_BNE;
            OP_J:                              id_target = ST_J;
            OP_JAL:                            id_target = ST_JAL;
            OP_LUI:                            id_target = ST_LUI_WB;
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: id_target = ST_I_EXE;
            default:                           id_target = ERR_STATE;
        endcase
    end

    always_comb begin
        r_alu = ALU_ADD;
        case (bus.Fun)
            F_SUB:   r_alu = ALU_SUB;
            F_AND:   r_alu = ALU_AND;
            F_OR:    r_alu = ALU_OR;
            F_SLT:   r_alu = ALU_SLT;
            F_NOR:   r_alu = ALU_NOR;
            default: r_alu = ALU_ADD;
        endcase
    end

    always_comb begin
        i_alu = ALU_ADD;
        case (bus.OPcode)
            OP_SLTI: i_alu = ALU_SLT;
            OP_ANDI: i_alu = ALU_AND;
            OP_ORI:  i_alu = ALU_OR;
            default: i_alu = ALU_ADD;
        endcase
    end

    // ---------------- next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IF:       if (bus.MIO_ready) state_d = ST_ID;
            ST_ID:       state_d = id_target;
            ST_R_EXE:    state_d = ST_R_WB;
            ST_I_EXE:    state_d = ST_I_WB;
            ST_MEM_ADDR: state_d = (bus.OPcode == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
            ST_MEM_RD:   if (bus.MIO_ready) state_d = ST_MEM_WB;
            ST_MEM_WR:   if (bus.MIO_ready) state_d = ST_IF;
            ST_R_WB, ST_I_WB, ST_MEM_WB, ST_BEQ, ST_BNE,
            ST_J, ST_JAL, ST_JR, ST_LUI_WB:
                         state_d = ST_IF;
            ERR_STATE:   state_d = ERR_STATE;
            // unused codes are treated as an illegal-instruction trap
            default:     state_d = ERR_STATE;
        endcase
    end

    // Overflow is captured as the execute state ends so the following
    // writeback state can suppress RegWrite; only signed add/sub/addi trap.
    always_comb begin
        ovf_d = ovf_q;
        case (state_q)
            ST_IF:    ovf_d = 1'b0;
            ST_R_EXE: ovf_d = bus.overflow & ((bus.Fun == F_ADD) | (bus.Fun == F_SUB));
            ST_I_EXE: ovf_d = bus.overflow & (bus.OPcode == OP_ADDI);
            default:  ovf_d = ovf_q;
        endcase
    end

    // ---------------- outputs ----------------
    always_comb begin
        bus.PCSource    = 2'b00;
        bus.lorD        = 1'b0;
        bus.ALU_Control = 3'b000;
        bus.ALUSrcA     = 1'b0;
        bus.ALUSrcB     = 2'b00;
        bus.RegWrite    = 1'b0;
        bus.RegDst      = 2'b00;
        bus.IRWrite     = 1'b0;
        bus.MemtoReg    = 2'b00;
        bus.PCWrite     = 1'b0;
        bus.PCWriteCond = 1'b0;
        bus.Branch      = 1'b0;
        bus.S           = 1'b0;
        bus.MemRead     = 1'b0;
        bus.MemWrite    = 1'b0;
        case (state_q)
            ST_IF: begin
                bus.MemRead     = 1'b1;
                bus.ALUSrcB     = 2'b01;
                bus.ALU_Control = ALU_ADD;
                bus.S           = 1'b1;
                // IR and PC+4 are only committed on the cycle memory delivers
                bus.IRWrite     = bus.MIO_ready;
                bus.PCWrite     = bus.MIO_ready;
            end
            ST_ID: begin
                bus.ALUSrcB     = 2'b11;
                bus.ALU_Control = ALU_ADD;
                bus.S           = 1'b1;
            end
            ST_R_EXE: begin
                bus.ALUSrcA     = 1'b1;
                bus.ALU_Control = r_alu;
            end
            ST_R_WB: begin
                bus.RegDst   = 2'b01;
                bus.RegWrite = ~ovf_q;
            end
            ST_I_EXE: begin
                bus.ALUSrcA     = 1'b1;
                bus.ALUSrcB     = 2'b10;
                bus.S           = ~((bus.OPcode == OP_ANDI) | (bus.OPcode == OP_ORI));
                bus.ALU_Control = i_alu;
            end
            ST_I_WB: bus.RegWrite = ~ovf_q;
            ST_MEM_ADDR: begin
                bus.ALUSrcA     = 1'b1;
                bus.ALUSrcB     = 2'b10;
                bus.S           = 1'b1;
                bus.ALU_Control = ALU_ADD;
            end
            ST_MEM_RD: begin
                bus.lorD    = 1'b1;
                bus.MemRead = 1'b1;
            end
            ST_MEM_WB: begin
                bus.MemtoReg = 2'b01;
                bus.RegWrite = 1'b1;
            end
            ST_MEM_WR: begin
                bus.lorD     = 1'b1;
                bus.MemWrite = 1'b1;
            end
            ST_BEQ, ST_BNE: begin
                bus.ALUSrcA     = 1'b1;
                bus.ALU_Control = ALU_SUB;
                bus.PCSource    = 2'b01;
                bus.PCWriteCond = 1'b1;
                bus.Branch      = (state_q == ST_BEQ);
            end
            ST_J: begin
                bus.PCSource = 2'b10;
                bus.PCWrite  = 1'b1;
            end
            ST_JAL: begin
                bus.PCSource = 2'b10;
                bus.PCWrite  = 1'b1;
                bus.RegDst   = 2'b10;
                bus.MemtoReg = 2'b11;
                bus.RegWrite = 1'b1;
            end
            ST_JR: begin
                bus.PCSource = 2'b11;
                bus.PCWrite  = 1'b1;
            end
            ST_LUI_WB: begin
                bus.MemtoReg = 2'b10;
                bus.RegWrite = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.state_out = state_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
module tb_mc_ctrl_fsm;

    logic clk;
    logic rst;
    mc_ctrl_fsm_if bus();

    mc_ctrl_fsm #(.RESET_STATE(5'd0), .ERR_STATE(5'd31)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] st;
        logic [1:0] pcsrc;
        logic       lord;
        logic [2:0] alu;
        logic       srca;
        logic [1:0] srcb;
        logic       regwr;
        logic [1:0] regdst;
        logic       irwr;
        logic [1:0] m2r;
        logic       pcwr;
        logic       pccond;
        logic       br;
        logic       s;
        logic       mrd;
        logic       mwr;
    } obs_t;

    typedef struct {
        logic rdy;
        logic ov;
        obs_t e;
    } step_t;

    step_t sq[$];
    int checks = 0;
    int errors = 0;

    function automatic obs_t sample();
        obs_t o;
        o = {bus.state_out, bus.PCSource, bus.lorD, bus.ALU_Control, bus.ALUSrcA,
             bus.ALUSrcB, bus.RegWrite, bus.RegDst, bus.IRWrite, bus.MemtoReg,
             bus.PCWrite, bus.PCWriteCond, bus.Branch, bus.S, bus.MemRead,
             bus.MemWrite};
        return o;
    endfunction

    // Expected strobes per state, written from the controller's state table.
    // f: MIO_ready in IF, RegWrite in R_WB/I_WB, sign-extend in I_EXE.
    function automatic obs_t ex(input logic [4:0] st, input logic [2:0] alu, input logic f);
        obs_t e;
        e = '0;
        e.st = st;
        case (st)
            5'd0:  begin e.mrd = 1; e.srcb = 2'b01; e.alu = 3'b010; e.s = 1; e.irwr = f; e.pcwr = f; end
            5'd1:  begin e.srcb = 2'b11; e.alu = 3'b010; e.s = 1; end
            5'd2:  begin e.srca = 1; e.alu = alu; end
            5'd3:  begin e.regdst = 2'b01; e.regwr = f; end
            5'd4:  begin e.srca = 1; e.srcb = 2'b10; e.s = f; e.alu = alu; end
            5'd5:  begin e.regwr = f; end
            5'd6:  begin e.srca = 1; e.srcb = 2'b10; e.s = 1; e.alu = 3'b010; end
            5'd7:  begin e.lord = 1; e.mrd = 1; end
            5'd8:  begin e.m2r = 2'b01; e.regwr = 1; end
            5'd9:  begin e.lord = 1; e.mwr = 1; end
            5'd10, 5'd11: begin
                e.srca = 1; e.alu = 3'b110; e.pcsrc = 2'b01; e.pccond = 1; e.br = (st == 5'd10);
            end
            5'd12: begin e.pcsrc = 2'b10; e.pcwr = 1; end
            5'd13: begin e.pcsrc = 2'b10; e.pcwr = 1; e.regdst = 2'b10; e.m2r = 2'b11; e.regwr = 1; end
            5'd14: begin e.pcsrc = 2'b11; e.pcwr = 1; end
            5'd15: begin e.m2r = 2'b10; e.regwr = 1; end
            default: ;
        endcase
        return e;
    endfunction

    task automatic push(input logic rdy, input logic ov, input obs_t e);
        step_t sp;
        sp.rdy = rdy;
        sp.ov  = ov;
        sp.e   = e;
        sq.push_back(sp);
    endtask

    task automatic test_reset();
        obs_t got;
        step_t sp;
        rst = 1'b1;
        bus.OPcode = 6'b001111;
        bus.Fun = 6'd0;
        bus.MIO_ready = 1'b0;
        bus.zero = 1'b0;
        bus.overflow = 1'b0;
        #1;
        got = sample();
        checks++;
        if (got !== ex(5'd0, 3'b0, 1'b0)) begin
            errors++;
            $display("FAIL reset_state got=%h exp=%h", got, ex(5'd0, 3'b0, 1'b0));
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        repeat (3) push(1'b0, 1'b0, ex(5'd0, 3'b0, 1'b0));
        push(1'b1, 1'b0, ex(5'd0, 3'b0, 1'b1));
        push(1'b1, 1'b0, ex(5'd1, 3'b0, 1'b0));
        push(1'b1, 1'b0, ex(5'd15, 3'b0, 1'b0));
        push(1'b1, 1'b0, ex(5'd0, 3'b0, 1'b1));
        push(1'b1, 1'b0, ex(5'd1, 3'b0, 1'b0));
        push(1'b1, 1'b0, ex(5'd15, 3'b0, 1'b0));
        while (sq.size() > 0) begin
            sp = sq.pop_front();
            bus.MIO_ready = sp.rdy; bus.overflow = sp.ov;
            #1; got = sample(); checks++;
            if (got !== sp.e) begin
                errors++;
                $display("FAIL reset_fetch got=%h exp=%h", got, sp.e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_r_type();
        // funct, expected ALU code, overflow in R_EXE, expected RegWrite
        logic [5:0] fn  [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111};
        logic [2:0] alu [6] = '{3'b010,    3'b110,    3'b000,    3'b001,    3'b111,    3'b100};
        logic       ov  [6] = '{1'b0,      1'b1,      1'b1,      1'b0,      1'b1,      1'b0};
        logic       wr  [6] = '{1'b1,      1'b0,      1'b1,      1'b1,      1'b1,      1'b1};
        obs_t got;
        step_t sp;
        for (int i = 0; i < 6; i++) begin
            bus.OPcode = 6'b000000;
            bus.Fun = fn[i];
            push(1'b1, 1'b0, ex(5'd0, 3'b0, 1'b1));
            push(1'b1, 1'b0, ex(5'd1, 3'b0, 1'b0));
            push(1'b1, ov[i], ex(5'd2, alu[i], 1'b0));
            push(1'b1, 1'b0, ex(5'd3, 3'b0, wr[i]));
            while (sq.size() > 0) begin
                sp = sq.pop_front();
                bus.MIO_ready = sp.rdy; bus.overflow = sp.ov;
                #1; got = sample(); checks++;
                if (got !== sp.e) begin
                    errors++;
                    $display("FAIL r_type fun=%b got=%h exp=%h", fn[i], got, sp.e);
                end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_i_type();
        logic [5:0] op  [5] = '{6'b001000, 6'b001000, 6'b001100, 6'b001101, 6'b001010};
        logic [2:0] alu [5] = '{3'b010,    3'b010,    3'b000,    3'b001,    3'b111};
        logic       sx  [5] = '{1'b1,      1'b1,      1'b0,      1'b0,      1'b1};
        logic       ov  [5] = '{1'b1,      1'b0,      1'b1,      1'b0,      1'b1};
        logic       wr  [5] = '{1'b0,      1'b1,      1'b1,      1'b1,      1'b1};
        obs_t got;
        step_t sp;
        for (int i = 0; i < 5; i++) begin
            bus.OPcode = op[i];
            bus.Fun = 6'b000000;
            push(1'b1, 1'b0, ex(5'd0, 3'b0, 1'b1));
            push(1'b1, 1'b0, ex(5'd1, 3'b0, 1'b0));
            push(1'b1, ov[i], ex(5'd4, alu[i], sx[i]));
            push(1'b1, 1'b0, ex(5'd5, 3'b0, wr[i]));
            while (sq.size() > 0) begin
                sp = sq.pop_front();
                bus.MIO_ready = sp.rdy; bus.overflow = sp.ov;
                #1; got = sample(); checks++;
                if (got !== sp.e) begin
                    errors++;
                    $display("FAIL i_type op=%b got=%h exp=%h", op[i], got, sp.e);
                end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_mem();
        obs_t got;
        step_t sp;
        // lw with a fetch stall and a two-cycle read stall
        bus.OPcode = 6'b100011;
        bus.Fun = 6'd0;
        push(1'b0, 1'b0, ex(5'd0, 3'b0, 1'b0));
        push(1'b1, 1'b0, ex(5'd0, 3'b0, 1'b1));
        push(1'b1, 1'b0, ex(5'd1, 3'b0, 1'b0));
        push(1'b1, 1'b0, ex(5'd6, 3'b0, 1'b0));
        push(1'b0, 1'b0, ex(5'd7, 3'b0, 1'b0));
        push(1'b0, 1'b0, ex(5'd7, 3'b0, 1'b0));
        push(1'b1, 1'b0, ex(5'd7, 3'b0, 1'b0));
        push(1'b1, 1'b0, ex(5'd8, 3'b0, 1'b0));
        while (sq.size() > 0) begin
            sp = sq.pop_front();
            bus.MIO_ready = sp.rdy; bus.overflow = sp.ov;
            #1; got = sample(); checks++;
            if (got !== sp.e) begin
                errors++;
                $display("FAIL lw_stall got=%h exp=%h", got, sp.e);
            end
            @(posedge clk); #1;
        end
        // sw with one write stall
        bus.OPcode = 6'b101011;
        push(1'b1, 1'b0, ex(5'd0, 3'b0, 1'b1));
        push(1'b1, 1'b0, ex(5'd1, 3'b0, 1'b0));
        push(1'b1, 1'b0, ex(5'd6, 3'b0, 1'b0));
        push(1'b0, 1'b0, ex(5'd9, 3'b0, 1'b0));
        push(1'b1, 1'b0, ex(5'd9, 3'b0, 1'b0));
        while (sq.size() > 0) begin
            sp = sq.pop_front();
            bus.MIO_ready = sp.rdy; bus.overflow = sp.ov;
            #1; got = sample(); checks++;
            if (got !== sp.e) begin
                errors++;
                $display("FAIL sw got=%h exp=%h", got, sp.e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch_jump();
        logic [5:0] op [6] = '{6'b000100, 6'b000101, 6'b000010, 6'b000011, 6'b000000, 6'b001111};
        logic [5:0] fn [6] = '{6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b001000, 6'b000000};
        logic [4:0] st [6] = '{5'd10,     5'd11,     5'd12,     5'd13,     5'd14,     5'd15};
        obs_t got;
        step_t sp;
        for (int i = 0; i < 6; i++) begin
            bus.OPcode = op[i];
            bus.Fun = fn[i];
            bus.zero = i[0];
            push(1'b1, 1'b0, ex(5'd0, 3'b0, 1'b1));
            push(1'b1, 1'b0, ex(5'd1, 3'b0, 1'b0));
            push(1'b1, 1'b0, ex(st[i], 3'b0, 1'b0));
            while (sq.size() > 0) begin
                sp = sq.pop_front();
                bus.MIO_ready = sp.rdy; bus.overflow = sp.ov;
                #1; got = sample(); checks++;
                if (got !== sp.e) begin
                    errors++;
                    $display("FAIL branch_jump op=%b got=%h exp=%h", op[i], got, sp.e);
                end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_err_trap();
        logic [5:0] op [2] = '{6'b111111, 6'b000000};
        logic [5:0] fn [2] = '{6'b000000, 6'b000001};
        obs_t got;
        step_t sp;
        for (int i = 0; i < 2; i++) begin
            bus.OPcode = op[i];
            bus.Fun = fn[i];
            push(1'b1, 1'b0, ex(5'd0, 3'b0, 1'b1));
            push(1'b1, 1'b0, ex(5'd1, 3'b0, 1'b0));
            repeat (5) push(1'b1, 1'b1, ex(5'd31, 3'b0, 1'b0));
            while (sq.size() > 0) begin
                sp = sq.pop_front();
                bus.MIO_ready = sp.rdy; bus.overflow = sp.ov;
                #1; got = sample(); checks++;
                if (got !== sp.e) begin
                    errors++;
                    $display("FAIL err_trap op=%b fun=%b got=%h exp=%h", op[i], fn[i], got, sp.e);
                end
                @(posedge clk); #1;
            end
            bus.MIO_ready = 1'b0;
            #2 rst = 1'b1;
            #1; got = sample(); checks++;
            if (got !== ex(5'd0, 3'b0, 1'b0)) begin
                errors++;
                $display("FAIL err_reset got=%h exp=%h", got, ex(5'd0, 3'b0, 1'b0));
            end
            @(negedge clk) rst = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid();
        obs_t got;
        step_t sp;
        bus.OPcode = 6'b100011;
        bus.Fun = 6'd0;
        push(1'b1, 1'b0, ex(5'd0, 3'b0, 1'b1));
        push(1'b1, 1'b0, ex(5'd1, 3'b0, 1'b0));
        push(1'b1, 1'b0, ex(5'd6, 3'b0, 1'b0));
        while (sq.size() > 0) begin
            sp = sq.pop_front();
            bus.MIO_ready = sp.rdy; bus.overflow = sp.ov;
            #1; got = sample(); checks++;
            if (got !== sp.e) begin
                errors++;
                $display("FAIL mid_reset_pre got=%h exp=%h", got, sp.e);
            end
            @(posedge clk); #1;
        end
        bus.MIO_ready = 1'b0;
        #1; got = sample(); checks++;
        if (got !== ex(5'd7, 3'b0, 1'b0)) begin
            errors++;
            $display("FAIL mid_reset_rd got=%h exp=%h", got, ex(5'd7, 3'b0, 1'b0));
        end
        // reset lands mid-cycle, away from any clock edge
        #1 rst = 1'b1;
        #1; got = sample(); checks++;
        if (got !== ex(5'd0, 3'b0, 1'b0)) begin
            errors++;
            $display("FAIL mid_reset_async got=%h exp=%h", got, ex(5'd0, 3'b0, 1'b0));
        end
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        got = sample(); checks++;
        if (got !== ex(5'd0, 3'b0, 1'b0)) begin
            errors++;
            $display("FAIL mid_reset_hold got=%h exp=%h", got, ex(5'd0, 3'b0, 1'b0));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_r_type();
        test_i_type();
        test_mem();
        test_branch_jump();
        test_err_trap();
        test_reset_mid();
        test_r_type();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
